// File: rtl/nn_uart_pkg.sv
// Shared definitions for the UART receive path and the frame decoder:
// decoder state encoding, default framing marker and line timing constants.
package nn_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHECK,
        ST_HOLD
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         CLK_PER_BIT       = 5208;
    // Ten bit-times: one full character slot of silence between bytes.
    localparam int         TIMEOUT_DEFAULT   = 10 * CLK_PER_BIT;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_decoder_if.sv
// Byte-in / vector-out bundle between the UART receiver, the frame decoder
// and the neural-network core.
interface uart_frame_decoder_if #(
    parameter int N_INPUTS = 4,
    parameter int DATA_W   = 8
);
    logic                       rx_valid;
    logic [DATA_W-1:0]          rx_data;
    logic [N_INPUTS*DATA_W-1:0] vec_data;
    logic                       vec_valid;
    logic                       vec_ready;
    logic                       busy;
    logic                       err_chk;
    logic                       err_len;
    logic                       err_timeout;
    logic                       err_overrun;

    modport master (
        output rx_valid, rx_data, vec_ready,
        input  vec_data, vec_valid, busy,
        input  err_chk, err_len, err_timeout, err_overrun
    );

    modport slave (
        input  rx_valid, rx_data, vec_ready,
        output vec_data, vec_valid, busy,
        output err_chk, err_len, err_timeout, err_overrun
    );
endinterface

// File: rtl/gap_timer.sv
// Idle-gap counter: counts enabled cycles up to a loadable limit and flags
// when the limit is reached; also used by the UART receiver for line idle.
module gap_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Saturates at the limit so a late reaction never wraps back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != limit)) begin
            count <= count + WIDTH'(1);
        end
    end

    assign expired = en && (count == limit);

endmodule

// File: rtl/uart_frame_decoder.sv
// Assembles SYNC/LEN/payload/CHK frames from received bytes and presents the
// payload as one vector through a valid/ready handshake.
module uart_frame_decoder
    import nn_uart_pkg::*;
#(
    parameter int                N_INPUTS       = 4,
    parameter int                DATA_W         = 8,
    parameter logic [DATA_W-1:0] SYNC_BYTE      = DATA_W'(SYNC_BYTE_DEFAULT),
    parameter int                TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input logic                clk,
    input logic                rst,
    uart_frame_decoder_if.slave bus
);

    localparam int                IDX_W    = idx_width(N_INPUTS);
    localparam int                GAP_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_INPUTS - 1);
    localparam logic [DATA_W-1:0] LEN_VAL  = DATA_W'(N_INPUTS);
    localparam logic [GAP_W-1:0]  GAP_LIM  = GAP_W'(TIMEOUT_CYCLES);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] chk;
    logic [DATA_W-1:0] slot [N_INPUTS];
    logic              vec_valid;
    logic              err_chk;
    logic              err_len;
    logic              err_timeout;
    logic              err_overrun;
    logic              in_frame;
    logic              gap_expired;
    logic              timeout;

    assign in_frame = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHECK);

    // Held clear outside a frame, so entry to LEN always starts from zero.
    gap_timer #(
        .WIDTH (GAP_W)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (bus.rx_valid || !in_frame),
        .en      (in_frame),
        .limit   (GAP_LIM),
        .expired (gap_expired)
    );

    // A byte landing on the expiry cycle beats the timeout.
    assign timeout = gap_expired && !bus.rx_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            chk         <= '0;
            vec_valid   <= 1'b0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            for (int i = 0; i < N_INPUTS; i++) begin
                slot[i] <= '0;
            end
        end else begin
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
                        state <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data == LEN_VAL) begin
                            chk   <= bus.rx_data;
                            idx   <= '0;
                            state <= ST_PAYLOAD;
                        end else begin
                            err_len <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end else if (timeout) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_PAYLOAD: begin
                    if (bus.rx_valid) begin
                        slot[idx] <= bus.rx_data;
                        chk       <= chk ^ bus.rx_data;
                        idx       <= idx + IDX_W'(1);
                        if (idx == LAST_IDX) begin
                            state <= ST_CHECK;
                        end
                    end else if (timeout) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data == chk) begin
                            vec_valid <= 1'b1;
                            state     <= ST_HOLD;
                        end else begin
                            err_chk <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end else if (timeout) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    // Bytes here are dropped outright, even a SYNC value.
                    if (bus.rx_valid) begin
                        err_overrun <= 1'b1;
                    end
                    if (bus.vec_ready) begin
                        vec_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < N_INPUTS; g++) begin : g_pack
        assign bus.vec_data[g*DATA_W +: DATA_W] = slot[g];
    end

    assign bus.vec_valid   = vec_valid;
    assign bus.busy        = (state != ST_IDLE);
    assign bus.err_chk     = err_chk;
    assign bus.err_len     = err_len;
    assign bus.err_timeout = err_timeout;
    assign bus.err_overrun = err_overrun;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Scoreboard bench for uart_frame_decoder: frames are built with a known
// intended outcome, queued as expected events, and matched by a monitor.
module tb_uart_frame_decoder;

    localparam int         N    = 4;
    localparam int         T    = 40;
    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum int {K_VEC, K_CHK, K_LEN, K_TMO, K_OVR} kind_t;
    typedef struct {
        kind_t          kind;
        logic [N*8-1:0] data;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    logic clk   = 1'b0;
    logic rst   = 1'b1;

    uart_frame_decoder_if #(.N_INPUTS(N), .DATA_W(8)) bus ();

    uart_frame_decoder #(
        .N_INPUTS       (N),
        .DATA_W         (8),
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic void expect_evt(input kind_t k, input logic [N*8-1:0] d);
        exp_t e;
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: actual=%s required=none", k.name());
            return;
        end
        e = q.pop_front();
        check({"event_kind_", e.kind.name()}, 64'(k), 64'(e.kind));
        if (k == K_VEC && e.kind == K_VEC) check("vec_data", d, e.data);
    endfunction

    // Reference: checksum is LEN xor every payload byte.
    function automatic logic [7:0] ref_chk(input logic [N*8-1:0] p);
        logic [7:0] c;
        c = 8'(N);
        for (int i = 0; i < N; i++) c ^= p[i*8 +: 8];
        return c;
    endfunction

    function automatic logic [N*8-1:0] rand_payload();
        logic [N*8-1:0] p;
        for (int i = 0; i < N; i++) p[i*8 +: 8] = 8'($urandom);
        return p;
    endfunction

    always @(negedge clk) begin : monitor
        int    n_err;
        kind_t k;
        if (!rst) begin
            n_err = int'(bus.err_chk) + int'(bus.err_len) + int'(bus.err_timeout) + int'(bus.err_overrun);
            if (n_err != 0) begin
                check("err_onehot", 64'(n_err), 64'd1);
                k = bus.err_chk ? K_CHK : bus.err_len ? K_LEN : bus.err_timeout ? K_TMO : K_OVR;
                if (k != K_OVR) check("busy_on_err", bus.busy, 0);
                expect_evt(k, '0);
            end
            if (bus.vec_valid && bus.vec_ready) expect_evt(K_VEC, bus.vec_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_noise();
        logic [7:0] b;
        repeat ($urandom_range(1, 3)) begin
            b = 8'($urandom);
            if (b == SYNC) b = 8'h5A;
            send_byte(b);
            idle($urandom_range(0, 2));
        end
    endtask

    // near_miss places one inter-byte gap of exactly T idle cycles.
    task automatic send_frame(input logic [N*8-1:0] p, input logic [7:0] chk, input bit near_miss);
        logic [7:0] bytes [N+2];
        int         slot;
        slot = near_miss ? int'($urandom_range(0, N + 1)) : -1;
        bytes[0] = 8'(N);
        for (int i = 0; i < N; i++) bytes[i+1] = p[i*8 +: 8];
        bytes[N+1] = chk;
        send_byte(SYNC);
        for (int i = 0; i < N + 2; i++) begin
            if (i == slot) idle(T);
            else idle($urandom_range(0, 2));
            send_byte(bytes[i]);
        end
    endtask

    task automatic do_good(input logic [N*8-1:0] p, input bit near_miss);
        bus.vec_ready = 1'b1;
        q.push_back('{K_VEC, p});
        send_frame(p, ref_chk(p), near_miss);
        check("vec_valid_latency", bus.vec_valid, 1);
        idle(1);
        check("vec_valid_after_accept", bus.vec_valid, 0);
    endtask

    task automatic do_bad_chk(input logic [N*8-1:0] p, input logic [7:0] chk);
        bus.vec_ready = 1'($urandom);
        q.push_back('{K_CHK, '0});
        send_frame(p, chk, 1'b0);
        check("busy_after_chk_err", bus.busy, 0);
        check("no_vec_on_chk_err", bus.vec_valid, 0);
    endtask

    task automatic do_bad_len(input logic [7:0] len);
        q.push_back('{K_LEN, '0});
        send_byte(SYNC);
        idle($urandom_range(0, 2));
        send_byte(len);
        check("busy_after_len_err", bus.busy, 0);
    endtask

    // Sends SYNC plus m correct bytes, then stays silent until the timeout.
    task automatic do_timeout(input logic [N*8-1:0] p, input int m);
        bus.vec_ready = 1'($urandom);
        send_byte(SYNC);
        for (int i = 0; i < m; i++) begin
            idle($urandom_range(0, 2));
            send_byte(i == 0 ? 8'(N) : p[(i-1)*8 +: 8]);
        end
        q.push_back('{K_TMO, '0});
        idle(T);
        check("busy_before_timeout", bus.busy, 1);
        idle(1);
        check("busy_after_timeout", bus.busy, 0);
    endtask

    task automatic do_hold(input logic [N*8-1:0] p);
        logic [7:0] b;
        bus.vec_ready = 1'b0;
        send_frame(p, ref_chk(p), 1'b0);
        check("vec_valid_hold_latency", bus.vec_valid, 1);
        repeat ($urandom_range(1, 4)) begin
            if ($urandom_range(0, 1) == 1) begin
                b = ($urandom_range(0, 1) == 1) ? SYNC : 8'($urandom);
                q.push_back('{K_OVR, '0});
                send_byte(b);
            end else begin
                idle(1);
            end
            check("vec_data_stable", bus.vec_data, p);
            check("vec_valid_held", bus.vec_valid, 1);
        end
        bus.vec_ready = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
            q.push_back('{K_VEC, p});
            q.push_back('{K_OVR, '0});
            send_byte(SYNC);
        end else begin
            q.push_back('{K_VEC, p});
            idle(1);
        end
        check("vec_valid_after_hold", bus.vec_valid, 0);
        check("busy_after_hold", bus.busy, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_vec_valid"}, bus.vec_valid, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_err"}, {bus.err_chk, bus.err_len, bus.err_timeout, bus.err_overrun}, 0);
        check({tag, "_vec_data"}, bus.vec_data, 0);
    endtask

    task automatic do_reset_mid(input logic [N*8-1:0] p, input int m, input bit in_hold);
        if (in_hold) begin
            bus.vec_ready = 1'b0;
            send_frame(p, ref_chk(p), 1'b0);
            idle($urandom_range(0, 3));
        end else begin
            send_byte(SYNC);
            for (int i = 0; i < m; i++) send_byte(i == 0 ? 8'(N) : p[(i-1)*8 +: 8]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals(in_hold ? "rst_hold" : "rst_mid");
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [N*8-1:0] p;
        logic [7:0]     len;
        int             r;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = '0;
        bus.vec_ready = 1'b0;
        rst = 1'b1;
        tick();
        check_reset_vals("reset");
        tick();
        rst = 1'b0;
        idle(2);

        p = 32'h44332211;
        check("ref_chk_example", 64'(ref_chk(p)), 64'h40);
        do_good(p, 1'b0);
        do_bad_chk(p, 8'h41);
        do_bad_len(8'h03);
        do_good(p, 1'b0);
        do_timeout(p, 3);
        do_good(p, 1'b1);
        do_hold(p);
        do_good(32'hA5A5A5A5, 1'b0);
        do_reset_mid(p, 3, 1'b0);
        do_good(p, 1'b0);
        do_reset_mid(p, 0, 1'b1);
        do_good(p, 1'b0);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 2) == 0) send_noise();
            p = rand_payload();
            r = $urandom_range(0, 10);
            case (r)
                0, 1, 2: do_good(p, 1'b0);
                3:       do_good(p, 1'b1);
                4:       do_bad_chk(p, ref_chk(p) ^ 8'($urandom_range(1, 255)));
                5: begin
                    len = 8'($urandom);
                    if (len == 8'(N)) len = len + 8'd1;
                    do_bad_len(len);
                end
                6:       do_timeout(p, $urandom_range(0, N + 1));
                7, 8:    do_hold(p);
                9:       do_reset_mid(p, $urandom_range(0, N + 1), 1'b0);
                default: do_reset_mid(p, 0, 1'b1);
            endcase
            idle($urandom_range(0, 2));
        end

        idle(2 * T);
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
